// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral bus responder: register offsets,
// CTRL field layout, reset constants, the decoded request and helpers.
package periph_pkg;

  // Register offsets within the 4 kB window
  localparam logic [11:0] OFF_LED         = 12'h000;
  localparam logic [11:0] OFF_CTRL        = 12'h004;
  localparam logic [11:0] OFF_MTIME_LO    = 12'h008;
  localparam logic [11:0] OFF_MTIME_HI    = 12'h00C;
  localparam logic [11:0] OFF_MTIMECMP_LO = 12'h010;
  localparam logic [11:0] OFF_MTIMECMP_HI = 12'h014;
  localparam logic [11:0] OFF_STATUS      = 12'h018;

  // CTRL field positions
  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int CTRL_PRESCALE_MSB = 15;
  localparam int PRESCALE_W        = CTRL_PRESCALE_MSB - CTRL_PRESCALE_LSB + 1;

  // Reset constants
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // One request as seen in its grant cycle
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [11:0] offset;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        hit;
  } req_t;

  // Replace only the bytes whose enable is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return result;
  endfunction

  // True for every offset that names a register
  function automatic logic offset_mapped(input logic [11:0] off);
    logic mapped;
    case (off)
      OFF_LED, OFF_CTRL, OFF_MTIME_LO, OFF_MTIME_HI,
      OFF_MTIMECMP_LO, OFF_MTIMECMP_HI, OFF_STATUS: mapped = 1'b1;
      default:                                      mapped = 1'b0;
    endcase
    return mapped;
  endfunction

endpackage

// File: rtl/periph_mtimer.sv
// Machine timer: prescaler, 64-bit MTIME and MTIMECMP with byte-enabled
// write ports, and the registered timer interrupt.
module periph_mtimer
  import periph_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  ctrl_wr,
  input  logic                  mtime_lo_wr,
  input  logic                  mtime_hi_wr,
  input  logic                  cmp_lo_wr,
  input  logic                  cmp_hi_wr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [63:0]           mtime,
  output logic [63:0]           mtimecmp,
  output logic                  irq
);

  logic [PRESCALE_W-1:0] count_q;
  logic [63:0]           mtime_q;
  logic [63:0]           mtime_d;
  logic [63:0]           cmp_q;
  logic                  irq_q;
  logic                  tick;

  assign tick = en && (count_q == prescale);

  // Next MTIME: increment on a prescaler tick unless a bus write lands this cycle
  always_comb begin
    // NOTE: default first so every path assigns mtime_d and no latch is inferred.
    mtime_d = mtime_q;
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    // A write with no byte enables is a no-op and does not swallow the tick
    if (mtime_lo_wr && (be != 4'b0000)) begin
      mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], wdata, be)};
    end else if (mtime_hi_wr && (be != 4'b0000)) begin
      mtime_d = {be_merge(mtime_q[63:32], wdata, be), mtime_q[31:0]};
    end
  end

  // Prescaler count: free-runs while enabled, restarts on a tick or any CTRL write
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_ni) begin
      count_q <= '0;
    end else if (ctrl_wr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tick ? '0 : count_q + 1'b1;
    end
  end

  // MTIME register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q <= '0;
    end else begin
      mtime_q <= mtime_d;
    end
  end

  // MTIMECMP register, byte-enabled per half
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmp_q <= MTIMECMP_RESET;
    end else if (cmp_lo_wr) begin
      cmp_q[31:0] <= be_merge(cmp_q[31:0], wdata, be);
    end else if (cmp_hi_wr) begin
      cmp_q[63:32] <= be_merge(cmp_q[63:32], wdata, be);
    end
  end

  // Level interrupt, registered from current timer state (one cycle of lag)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= en && (mtime_q >= cmp_q);
    end
  end

  assign mtime    = mtime_q;
  assign mtimecmp = cmp_q;
  assign irq      = irq_q;

endmodule

// File: rtl/periph_bus_responder.sv
// Data-side bus responder for the LED, control and machine-timer registers.
// Always grants; responds one cycle later with data or an error.
module periph_bus_responder
  import periph_pkg::*;
#(
  parameter logic [31:0] BaseAddr   = 32'h0001_0000,
  parameter logic [31:0] WindowMask = 32'h0000_0FFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic        err_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] led_o,
  output logic        timer_irq_o
);

  req_t                  req;
  logic                  wr_hit;
  logic                  rd_hit;
  logic [31:0]           read_data;

  logic [31:0]           led_q;
  logic                  ctrl_en_q;
  logic [PRESCALE_W-1:0] ctrl_prescale_q;
  logic [31:0]           mtime_hi_shadow_q;

  logic                  rvalid_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  irq;

  assign gnt_o = req_i;

  // Decode the request: window match, word alignment and a mapped offset
  always_comb begin
    req.valid  = req_i;
    req.write  = we_i;
    req.offset = addr_i[11:0];
    req.be     = be_i;
    req.wdata  = wdata_i;
    req.hit    = req_i
              && ((addr_i & ~WindowMask) == BaseAddr)
              && (addr_i[1:0] == 2'b00)
              && offset_mapped(addr_i[11:0]);
  end

  assign wr_hit = req.hit && req.write;
  assign rd_hit = req.hit && !req.write;

  // Read mux over register state as it stands at the grant edge
  always_comb begin
    read_data = '0;
    case (req.offset)
      OFF_LED: read_data = led_q;
      OFF_CTRL: begin
        read_data[CTRL_EN_BIT]                             = ctrl_en_q;
        read_data[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB]     = ctrl_prescale_q;
      end
      OFF_MTIME_LO:    read_data = mtime[31:0];
      OFF_MTIME_HI:    read_data = mtime_hi_shadow_q;
      OFF_MTIMECMP_LO: read_data = mtimecmp[31:0];
      OFF_MTIMECMP_HI: read_data = mtimecmp[63:32];
      OFF_STATUS:      read_data[0] = irq;
      default:         read_data = '0;
    endcase
  end

  // LED register, byte-enabled
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      led_q <= '0;
    end else if (wr_hit && (req.offset == OFF_LED)) begin
      led_q <= be_merge(led_q, req.wdata, req.be);
    end
  end

  // CTRL register: only EN and PRESCALE are stored, each in its own byte lane
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_en_q       <= 1'b0;
      ctrl_prescale_q <= '0;
    end else if (wr_hit && (req.offset == OFF_CTRL)) begin
      if (req.be[CTRL_EN_BIT / 8]) begin
        ctrl_en_q <= req.wdata[CTRL_EN_BIT];
      end
      if (req.be[CTRL_PRESCALE_LSB / 8]) begin
        ctrl_prescale_q <= req.wdata[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
      end
    end
  end

  // Reading MTIME_LO captures the upper half so a following HI read is coherent
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_hi_shadow_q <= '0;
    end else if (rd_hit && (req.offset == OFF_MTIME_LO)) begin
      mtime_hi_shadow_q <= mtime[63:32];
    end
  end

  // Response register: one pulse per grant, data only for successful reads
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= req.valid;
      err_q    <= req.valid && !req.hit;
      rdata_q  <= rd_hit ? read_data : '0;
    end
  end

  periph_mtimer u_mtimer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en          (ctrl_en_q),
    .prescale    (ctrl_prescale_q),
    .ctrl_wr     (wr_hit && (req.offset == OFF_CTRL)),
    .mtime_lo_wr (wr_hit && (req.offset == OFF_MTIME_LO)),
    .mtime_hi_wr (wr_hit && (req.offset == OFF_MTIME_HI)),
    .cmp_lo_wr   (wr_hit && (req.offset == OFF_MTIMECMP_LO)),
    .cmp_hi_wr   (wr_hit && (req.offset == OFF_MTIMECMP_HI)),
    .be          (req.be),
    .wdata       (req.wdata),
    .mtime       (mtime),
    .mtimecmp    (mtimecmp),
    .irq         (irq)
  );

  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign led_o       = led_q;
  assign timer_irq_o = irq;

endmodule
